vram_arbiter: RTL
=================

# vram_arbiter

Shares the single port of the 400x300 video RAM between display scanout and game-logic pixel writes. Display reads are generated from the row/col pixel coordinates produced by the VGA timing generator and always win their slot; writes are buffered in a small FIFO and drained into every free RAM cycle. It sits between the timing generator, the game renderer and the VRAM macro, and delivers the 2x-upscaled 800x600 pixel stream with a fixed latency.

## Interface

Parameters:

- H_DISPLAY, 800: visible columns.
- V_DISPLAY, 600: visible rows.
- ADDR_W, 17: VRAM address width.
- DATA_W, 12: pixel width (RGB444).
- FIFO_DEPTH, 4: write FIFO entries (power of two).
- VBLANK_ONLY, 0: when 1, writes are granted only while row >= V_DISPLAY (tear-free mode).

Ports:

- vga_clk  in  1  pixel clock; all logic on its rising edge.
- clrn  in  1  asynchronous, active-low reset.
- row  in  10  current pixel row from the timing generator.
- col  in  10  current pixel column from the timing generator.
- wr_valid  in  1  writer holds a pixel write.
- wr_ready  out  1  FIFO can accept; a write transfers when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  VRAM word address of the write.
- wr_data  in  DATA_W  pixel value to write.
- ram_addr  out  ADDR_W  VRAM address (registered).
- ram_we  out  1  VRAM write enable (registered).
- ram_wdata  out  DATA_W  VRAM write data (registered).
- ram_rdata  in  DATA_W  VRAM read data; valid one cycle after ram_addr.
- pixel  out  DATA_W  scanout pixel; 0 when not valid.
- pixel_valid  out  1  pixel belongs to the visible area.
- frame_tick  out  1  one-cycle pulse at the start of vertical blank.
- fifo_count  out  3  FIFO occupancy, 0..FIFO_DEPTH.

## Operation

- in_disp = (row < V_DISPLAY) && (col < H_DISPLAY).
- disp_slot = in_disp && (col[0] == 0).
- Display address = row[9:1]*400 + col[9:1]. The maximum is 119999, which fits ADDR_W=17. The multiply is done with shifts and adds (256+128+16).
- Arbitration, evaluated every cycle:
  - If disp_slot: next ram_addr = display address and ram_we = 0.
  - Otherwise, if the FIFO is non-empty and (VBLANK_ONLY == 0 || row >= V_DISPLAY): pop the head; next ram_addr = head addr, ram_we = 1, ram_wdata = head data.
  - Otherwise: ram_we = 0 and ram_addr holds its previous value.
- Display reads are never delayed or dropped. Writes get every odd visible column plus all of blanking.
- FIFO:
  - wr_ready = (fifo_count < FIFO_DEPTH), computed combinationally from the count.
  - Push and pop in the same cycle leave the count unchanged. A push while full is impossible because wr_ready is low.
  - Entries drain in order. No write reordering and no merging.
- Pixel register:
  - Loads ram_rdata only when the read issued two cycles earlier was a display read.
  - Otherwise it holds, so each stored pixel is shown on two columns. Vertical doubling comes from row[9:1].
- pixel_valid is in_disp delayed by 3 cycles. When pixel_valid = 0, the pixel output is forced to 0.
- frame_tick = 1 for exactly one cycle when (row == V_DISPLAY && col == 0) first becomes true; this uses a rising-edge detect.

## Timing

- Reset (clrn low, asynchronous): ram_addr = 0, ram_we = 0, ram_wdata = 0, pixel = 0, pixel_valid = 0, frame_tick = 0, FIFO empty, fifo_count = 0, all delay pipes cleared.
  - wr_ready = 1 from the first cycle after clrn rises.
  - Writes in flight or buffered at reset are discarded.
- Write path:
  - An accepted write is visible in fifo_count the next cycle.
  - Earliest ram_we assertion is 2 cycles after acceptance, when the FIFO was empty and the slot is free.
- Display path:
  - row/col presented in cycle t drives ram_addr in t+1 and ram_rdata in t+2.
  - pixel/pixel_valid correspond to that row/col in t+3. Total latency is 3 cycles.
- Simultaneous push, pop and display slot in one cycle: the display read wins, no pop occurs, and the count increments.
- Row/col jumps, such as timing-generator reset or wrap 599→0 or 799→0, need no special handling. Arbitration depends only on the current row/col.

## Test plan

- Reset mid-stream with 3 FIFO entries queued: all outputs go to 0 immediately, fifo_count = 0, and wr_ready = 1 one cycle after release.
- Drive row=10, col=20: ram_addr = 2010 and ram_we = 0 one cycle later. With ram_rdata = 12'hABC in the following cycle, pixel = 12'hABC and pixel_valid = 1 at t+3 and t+4 (cols 20 and 21).
- Blanking (row=650): a single write addr=5, data=12'h0F0 gives ram_we = 1, ram_addr = 5, ram_wdata = 12'h0F0 two cycles after acceptance.
- Visible line with 6 back-to-back writes:
  - wr_ready drops after 4 entries accumulate.
  - ram_we is asserted only in odd-column slots.
  - All 6 writes reach RAM in order, and no display read is missed.
- VBLANK_ONLY=1 with writes queued during the visible area: ram_we stays 0 until row reaches 600, then the FIFO drains on consecutive cycles.
- Sweep through a full frame: frame_tick pulses exactly once per frame, at row=600, col=0, and pixel_valid is high for exactly 800x600 cycles.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scanout reads own even visible columns,
// buffered game writes drain into every other RAM cycle; 2x upscaled output.
module vram_arbiter #(
    parameter int H_DISPLAY   = 800,
    parameter int V_DISPLAY   = 600,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int VBLANK_ONLY = 0
) (
    input  logic              vga_clk,
    input  logic              clrn,
    input  logic [9:0]        row,
    input  logic [9:0]        col,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_valid,
    output logic              frame_tick,
    output logic [2:0]        fifo_count
);

    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [9:0] H_LIM   = 10'(H_DISPLAY);
    localparam logic [9:0] V_LIM   = 10'(V_DISPLAY);
    localparam logic [2:0] CNT_MAX = 3'(FIFO_DEPTH);

    logic [ADDR_W+DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [2:0]               r_count;

    logic [ADDR_W-1:0]        r_ram_addr;
    logic                     r_ram_we;
    logic [DATA_W-1:0]        r_ram_wdata;
    logic                     r_rd_p1, r_rd_p2;
    logic                     r_vis_p1, r_vis_p2, r_vis_p3;
    logic [DATA_W-1:0]        r_pixel;
    logic                     r_ft_cond_d;
    logic                     r_frame_tick;

    logic                     w_in_disp;
    logic                     w_disp_slot;
    logic [8:0]               w_row_h;
    logic [8:0]               w_col_h;
    logic [ADDR_W-1:0]        w_disp_addr;
    logic                     w_wr_ok;
    logic                     w_push;
    logic                     w_pop;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic                     w_ft_cond;

    assign w_in_disp   = (row < V_LIM) && (col < H_LIM);
    assign w_disp_slot = w_in_disp && !col[0];
    assign w_row_h     = row[9:1];
    assign w_col_h     = col[9:1];
    // row_h * 400 as 256 + 128 + 16
    assign w_disp_addr = ADDR_W'({w_row_h, 8'd0}) + ADDR_W'({w_row_h, 7'd0})
                       + ADDR_W'({w_row_h, 4'd0}) + ADDR_W'(w_col_h);

    assign w_wr_ok   = (VBLANK_ONLY == 0) || (row >= V_LIM);
    assign wr_ready  = (r_count < CNT_MAX);
    assign w_push    = wr_valid && wr_ready;
    assign w_pop     = !w_disp_slot && (r_count != 3'd0) && w_wr_ok;
    assign w_head    = r_mem[r_rptr];
    assign w_ft_cond = (row == V_LIM) && (col == 10'd0);

    always_ff @(posedge vga_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Stage 1: RAM command; display slot always wins, else drain the FIFO head
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else if (w_disp_slot) begin
            r_ram_addr <= w_disp_addr;
            r_ram_we   <= 1'b0;
        end else if (w_pop) begin
            r_ram_addr  <= w_head[ADDR_W+DATA_W-1:DATA_W];
            r_ram_we    <= 1'b1;
            r_ram_wdata <= w_head[DATA_W-1:0];
        end else begin
            r_ram_we <= 1'b0;
        end
    end

    // Stages 2-3: track read type and visibility until RAM data returns
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_rd_p1      <= 1'b0;
            r_rd_p2      <= 1'b0;
            r_vis_p1     <= 1'b0;
            r_vis_p2     <= 1'b0;
            r_vis_p3     <= 1'b0;
            r_pixel      <= '0;
            r_ft_cond_d  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_rd_p1      <= w_disp_slot;
            r_rd_p2      <= r_rd_p1;
            r_vis_p1     <= w_in_disp;
            r_vis_p2     <= r_vis_p1;
            r_vis_p3     <= r_vis_p2;
            r_ft_cond_d  <= w_ft_cond;
            r_frame_tick <= w_ft_cond && !r_ft_cond_d;
            if (r_rd_p2) begin
                r_pixel <= ram_rdata;
            end
        end
    end

    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_wdata   = r_ram_wdata;
    assign pixel       = r_vis_p3 ? r_pixel : '0;
    assign pixel_valid = r_vis_p3;
    assign frame_tick  = r_frame_tick;
    assign fifo_count  = r_count;

endmodule
